// File: rtl/axil_arbiter_rr_wr.sv
// Round-robin arbiter for the shared AXI-Lite write path (AW, W, B); one grant spans a full write.
// Optional forced release of a stuck grant is enabled with `define AXIL_ARB_TIMEOUT_EN.
module axil_arbiter_rr_wr #(
    parameter int NUMBER_MASTER  = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUMBER_MASTER-1:0]         request_wr,
    output logic [NUMBER_MASTER-1:0]         grant_wr,
    output logic [$clog2(NUMBER_MASTER)-1:0] grant_wr_cdr,
    input  logic                             aw_hs,
    input  logic                             w_hs,
    input  logic                             s_axil_bvalid,
    input  logic [NUMBER_MASTER-1:0]         m_axil_bready,
    output logic                             busy,
    output logic                             timeout_err
);

    localparam int IDXW = $clog2(NUMBER_MASTER);

    if (NUMBER_MASTER < 2) begin : g_bad_number_master
        $error("axil_arbiter_rr_wr: NUMBER_MASTER must be at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cycles
        $error("axil_arbiter_rr_wr: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_next_state;
    logic [NUMBER_MASTER-1:0] r_grant;
    logic [IDXW-1:0]          r_cdr;
    logic [IDXW-1:0]          r_last_ptr;
    logic                     r_aw_done;
    logic                     r_w_done;

    logic                     w_found;
    logic [IDXW-1:0]          w_winner;
    logic [IDXW:0]            w_cand;
    logic                     w_data_done;
    logic                     w_b_hs;
    logic                     w_timeout;

    // Both halves of the write are in once the flags plus this cycle's handshakes cover AW and W.
    assign w_data_done = (r_aw_done | aw_hs) & (r_w_done | w_hs);
    assign w_b_hs      = s_axil_bvalid & m_axil_bready[r_cdr];

    // Scan from the master after the last winner, wrapping, so every requester is reached in turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int i = 1; i <= NUMBER_MASTER; i++) begin
            w_cand = {1'b0, r_last_ptr} + (IDXW+1)'(i);
            if (w_cand >= (IDXW+1)'(NUMBER_MASTER)) begin
                w_cand = w_cand - (IDXW+1)'(NUMBER_MASTER);
            end
            if (!w_found && request_wr[w_cand[IDXW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDXW-1:0];
            end
        end
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_tmo_cnt;
    logic          r_timeout_err;
    logic          w_complete;

    assign w_complete = ((r_state == DATA) && w_data_done) || ((r_state == RESP) && w_b_hs);
    assign w_timeout  = (r_state != IDLE) && (r_tmo_cnt >= TLAST) && !w_complete;

    // Counter saturates so a grant that overruns in RESP is still caught instead of wrapping.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if ((r_state == IDLE) && (w_next_state == DATA)) begin
                r_tmo_cnt <= '0;
            end else if ((r_state != IDLE) && (r_tmo_cnt != TMAX)) begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_found)     w_next_state = DATA;
            DATA:    if (w_data_done) w_next_state = RESP;
            RESP:    if (w_b_hs)      w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
        if (w_timeout) begin
            w_next_state = IDLE;
        end
    end

    // last_ptr only moves on a new grant, so it survives both normal and forced release.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_grant    <= '0;
            r_cdr      <= '0;
            r_last_ptr <= IDXW'(NUMBER_MASTER - 1);
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            if ((r_state == DATA) && (w_next_state == DATA)) begin
                r_aw_done <= r_aw_done | aw_hs;
                r_w_done  <= r_w_done | w_hs;
            end else begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if ((r_state == IDLE) && (w_next_state == DATA)) begin
                r_grant    <= {{(NUMBER_MASTER-1){1'b0}}, 1'b1} << w_winner;
                r_cdr      <= w_winner;
                r_last_ptr <= w_winner;
            end else if (w_next_state == IDLE) begin
                r_grant <= '0;
                r_cdr   <= '0;
            end
        end
    end

    always_comb begin
        busy         = (r_state != IDLE);
        grant_wr     = r_grant;
        grant_wr_cdr = r_cdr;
`ifdef AXIL_ARB_TIMEOUT_EN
        timeout_err  = r_timeout_err;
`else
        timeout_err  = 1'b0;
`endif
    end

endmodule

// File: tb/tb_axil_arbiter_rr_wr.sv
// Directed bench for axil_arbiter_rr_wr: reset, round-robin order, wrap, handshake order,
// async reset and (with AXIL_ARB_TIMEOUT_EN) forced release after 8 granted cycles.
module tb_axil_arbiter_rr_wr;

    localparam int NM = 4;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [NM-1:0] request_wr = '0;
    logic [NM-1:0] grant_wr;
    logic [1:0]    grant_wr_cdr;
    logic          aw_hs = 1'b0;
    logic          w_hs = 1'b0;
    logic          s_axil_bvalid = 1'b0;
    logic [NM-1:0] m_axil_bready = '0;
    logic          busy;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axil_arbiter_rr_wr #(
        .NUMBER_MASTER (NM),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .request_wr   (request_wr),
        .grant_wr     (grant_wr),
        .grant_wr_cdr (grant_wr_cdr),
        .aw_hs        (aw_hs),
        .w_hs         (w_hs),
        .s_axil_bvalid(s_axil_bvalid),
        .m_axil_bready(m_axil_bready),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // Called at a falling edge while in DATA: both handshakes, then the B handshake with the given bready.
    task automatic finish_txn(input logic [NM-1:0] bready_mask);
        aw_hs = 1'b1;
        w_hs  = 1'b1;
        @(negedge aclk);
        aw_hs         = 1'b0;
        w_hs          = 1'b0;
        s_axil_bvalid = 1'b1;
        m_axil_bready = bready_mask;
        @(negedge aclk);
        s_axil_bvalid = 1'b0;
        m_axil_bready = '0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        #3;
        checks++;
        if (grant_wr !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got=%b exp=%b", grant_wr, 4'b0000); end
        checks++;
        if (grant_wr_cdr !== 2'd0) begin errors++; $display("[TB] FAIL reset_cdr got=%0d exp=%0d", grant_wr_cdr, 0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err got=%b exp=%b", timeout_err, 1'b0); end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_single();
        @(negedge aclk);
        request_wr = 4'b0001;
        @(negedge aclk);
        checks++;
        if (grant_wr !== 4'b0001) begin errors++; $display("[TB] FAIL single_grant got=%b exp=%b", grant_wr, 4'b0001); end
        checks++;
        if (grant_wr_cdr !== 2'd0) begin errors++; $display("[TB] FAIL single_cdr got=%0d exp=%0d", grant_wr_cdr, 0); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL single_busy got=%b exp=%b", busy, 1'b1); end
        request_wr = '0;
        aw_hs = 1'b1;
        w_hs  = 1'b1;
        @(negedge aclk);
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        checks++;
        if (grant_wr !== 4'b0001) begin errors++; $display("[TB] FAIL single_resp_hold got=%b exp=%b", grant_wr, 4'b0001); end
        s_axil_bvalid = 1'b1;
        m_axil_bready = 4'b0001;
        @(negedge aclk);
        s_axil_bvalid = 1'b0;
        m_axil_bready = '0;
        checks++;
        if (grant_wr !== 4'b0000) begin errors++; $display("[TB] FAIL single_release got=%b exp=%b", grant_wr, 4'b0000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_release_busy got=%b exp=%b", busy, 1'b0); end
    endtask

    task automatic test_round_robin();
        int            exp_idx;
        logic [NM-1:0] exp_grant;
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn    = 1'b1;
        request_wr = 4'b1111;
        exp_idx    = 0;
        for (int k = 0; k < 5; k++) begin
            exp_grant = 4'b0001 << exp_idx;
            @(negedge aclk);
            checks++;
            if (grant_wr !== exp_grant) begin errors++; $display("[TB] FAIL rr_grant[%0d] got=%b exp=%b", k, grant_wr, exp_grant); end
            checks++;
            if (grant_wr_cdr !== 2'(exp_idx)) begin errors++; $display("[TB] FAIL rr_cdr[%0d] got=%0d exp=%0d", k, grant_wr_cdr, exp_idx); end
            finish_txn(4'b1111);
            checks++;
            if (grant_wr !== 4'b0000) begin errors++; $display("[TB] FAIL rr_idle_gap[%0d] got=%b exp=%b", k, grant_wr, 4'b0000); end
            exp_idx = (exp_idx + 1) % NM;
        end
        request_wr = '0;
    endtask

    task automatic test_wrap();
        request_wr = 4'b0010;
        @(negedge aclk);
        checks++;
        if (grant_wr !== 4'b0010) begin errors++; $display("[TB] FAIL wrap_setup got=%b exp=%b", grant_wr, 4'b0010); end
        request_wr = '0;
        finish_txn(4'b0010);
        request_wr = 4'b0011;
        @(negedge aclk);
        checks++;
        if (grant_wr !== 4'b0001) begin errors++; $display("[TB] FAIL wrap_grant got=%b exp=%b", grant_wr, 4'b0001); end
        checks++;
        if (grant_wr_cdr !== 2'd0) begin errors++; $display("[TB] FAIL wrap_cdr got=%0d exp=%0d", grant_wr_cdr, 0); end
        request_wr = '0;
        finish_txn(4'b0001);
    endtask

    task automatic test_hs_order();
        request_wr = 4'b0011;
        @(negedge aclk);
        checks++;
        if (grant_wr !== 4'b0010) begin errors++; $display("[TB] FAIL order_grant got=%b exp=%b", grant_wr, 4'b0010); end
        checks++;
        if (grant_wr_cdr !== 2'd1) begin errors++; $display("[TB] FAIL order_cdr got=%0d exp=%0d", grant_wr_cdr, 1); end
        request_wr = '0;
        w_hs = 1'b1;
        @(negedge aclk);
        w_hs = 1'b0;
        s_axil_bvalid = 1'b1;
        m_axil_bready = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            checks++;
            if (grant_wr !== 4'b0010) begin errors++; $display("[TB] FAIL order_wait_aw[%0d] got=%b exp=%b", k, grant_wr, 4'b0010); end
        end
        s_axil_bvalid = 1'b0;
        m_axil_bready = '0;
        aw_hs = 1'b1;
        @(negedge aclk);
        aw_hs = 1'b0;
        s_axil_bvalid = 1'b1;
        m_axil_bready = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            checks++;
            if (grant_wr !== 4'b0010) begin errors++; $display("[TB] FAIL order_wrong_bready[%0d] got=%b exp=%b", k, grant_wr, 4'b0010); end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("[TB] FAIL order_busy[%0d] got=%b exp=%b", k, busy, 1'b1); end
        end
        m_axil_bready = 4'b0010;
        @(negedge aclk);
        s_axil_bvalid = 1'b0;
        m_axil_bready = '0;
        checks++;
        if (grant_wr !== 4'b0000) begin errors++; $display("[TB] FAIL order_release got=%b exp=%b", grant_wr, 4'b0000); end
    endtask

    task automatic test_async_reset();
        request_wr = 4'b0100;
        @(negedge aclk);
        checks++;
        if (grant_wr !== 4'b0100) begin errors++; $display("[TB] FAIL areset_setup got=%b exp=%b", grant_wr, 4'b0100); end
        request_wr = '0;
        aw_hs = 1'b1;
        w_hs  = 1'b1;
        @(negedge aclk);
        aw_hs = 1'b0;
        w_hs  = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (grant_wr !== 4'b0000) begin errors++; $display("[TB] FAIL areset_grant got=%b exp=%b", grant_wr, 4'b0000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL areset_busy got=%b exp=%b", busy, 1'b0); end
        checks++;
        if (grant_wr_cdr !== 2'd0) begin errors++; $display("[TB] FAIL areset_cdr got=%0d exp=%0d", grant_wr_cdr, 0); end
        @(negedge aclk);
        aresetn    = 1'b1;
        request_wr = 4'b1111;
        @(negedge aclk);
        checks++;
        if (grant_wr !== 4'b0001) begin errors++; $display("[TB] FAIL areset_priority got=%b exp=%b", grant_wr, 4'b0001); end
        request_wr = '0;
        finish_txn(4'b0001);
    endtask

`ifdef AXIL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        request_wr = 4'b0010;
        for (int k = 0; k < 8; k++) begin
            @(negedge aclk);
            request_wr = '0;
            checks++;
            if (grant_wr !== 4'b0010) begin errors++; $display("[TB] FAIL tmo_hold[%0d] got=%b exp=%b", k, grant_wr, 4'b0010); end
            checks++;
            if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_early_pulse[%0d] got=%b exp=%b", k, timeout_err, 1'b0); end
        end
        @(negedge aclk);
        checks++;
        if (grant_wr !== 4'b0000) begin errors++; $display("[TB] FAIL tmo_release got=%b exp=%b", grant_wr, 4'b0000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL tmo_busy got=%b exp=%b", busy, 1'b0); end
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL tmo_pulse got=%b exp=%b", timeout_err, 1'b1); end
        request_wr = 4'b0011;
        @(negedge aclk);
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL tmo_pulse_width got=%b exp=%b", timeout_err, 1'b0); end
        checks++;
        if (grant_wr !== 4'b0001) begin errors++; $display("[TB] FAIL tmo_next_grant got=%b exp=%b", grant_wr, 4'b0001); end
        request_wr = '0;
        finish_txn(4'b0001);
    endtask
`else
    task automatic test_no_timeout();
        request_wr = 4'b0010;
        for (int k = 0; k < 12; k++) begin
            @(negedge aclk);
            request_wr = '0;
            checks++;
            if (grant_wr !== 4'b0010) begin errors++; $display("[TB] FAIL notmo_hold[%0d] got=%b exp=%b", k, grant_wr, 4'b0010); end
            checks++;
            if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL notmo_pulse[%0d] got=%b exp=%b", k, timeout_err, 1'b0); end
        end
        finish_txn(4'b0010);
        checks++;
        if (grant_wr !== 4'b0000) begin errors++; $display("[TB] FAIL notmo_release got=%b exp=%b", grant_wr, 4'b0000); end
    endtask
`endif

    initial begin
        $display("[TB] starting axil_arbiter_rr_wr bench");
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_hs_order();
        test_async_reset();
`ifdef AXIL_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
